// File: rtl/debug_pkg.sv
// rtl/debug_pkg.sv - shared encodings and defaults for the board debug port
package debug_pkg;

    typedef enum logic [1:0] {
        CMD_RUN   = 2'b00,
        CMD_HALT  = 2'b01,
        CMD_READ  = 2'b10,
        CMD_WRITE = 2'b11
    } cmd_e;

    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_HALT   = 2'b01,
        ST_ACCESS = 2'b10,
        ST_HOLD   = 2'b11
    } state_e;

    localparam int          TIMEOUT_DEFAULT     = 16;
    localparam logic [15:0] ERR_PATTERN_DEFAULT = 16'hEEEE;

    function automatic logic is_access_cmd(input logic [1:0] c);
        return (c == CMD_READ) || (c == CMD_WRITE);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for a bundle of asynchronous switch inputs
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/debug_port.sv
// rtl/debug_port.sv - switch-driven debug port: halts the CPU and performs single memory reads/writes
module debug_port
    import debug_pkg::*;
#(
    parameter int          TIMEOUT     = TIMEOUT_DEFAULT,
    parameter logic [15:0] ERR_PATTERN = ERR_PATTERN_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr_in,
    input  logic [31:0] data_in,
    input  logic [1:0]  cmd,
    output logic [15:0] data_out,
    output logic        cpu_halt,
    output logic        busy,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    localparam int SYNC_W  = 2 + 32 + 32;
    localparam int TIMER_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [SYNC_W-1:0]  sync_q;
    logic [1:0]         cmd_s;
    logic [31:0]        addr_s;
    logic [31:0]        data_s;

    state_e             state;
    state_e             state_next;
    logic [1:0]         cmd_reg;
    logic [31:0]        addr_reg;
    logic [TIMER_W-1:0] timer;

    logic               evt;
    logic               take_evt;
    logic               start_access;
    logic               ack_done;
    logic               abort;
    logic [1:0]         next_cmd;
    logic               rdata_unused;

    sync_2ff #(.WIDTH(SYNC_W)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     ({cmd, addr_in, data_in}),
        .q     (sync_q)
    );

    assign {cmd_s, addr_s, data_s} = sync_q;

    // Only the low half of read data reaches the display.
    assign rdata_unused = ^mem_rdata[31:16];

    assign evt = (cmd_s != cmd_reg) ||
                 ((cmd_s == CMD_READ) && (addr_s != addr_reg));

    assign next_cmd = take_evt ? cmd_s : cmd_reg;
    assign cpu_halt = (state != ST_RUN);
    assign busy     = (state == ST_ACCESS);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        take_evt     = 1'b0;
        start_access = 1'b0;
        ack_done     = 1'b0;
        abort        = 1'b0;
        case (state)
            ST_RUN: begin
                if (evt) begin
                    take_evt = 1'b1;
                    if (cmd_s == CMD_HALT) begin
                        state_next = ST_HOLD;
                    end else if (is_access_cmd(cmd_s)) begin
                        state_next = ST_HALT;
                    end
                end
            end
            ST_HALT: begin
                state_next   = ST_ACCESS;
                start_access = 1'b1;
            end
            ST_ACCESS: begin
                // Events are deliberately not taken here; HOLD picks them up afterwards.
                if (mem_ack) begin
                    ack_done   = 1'b1;
                    state_next = ST_HOLD;
                end else if (timer == TIMER_W'(TIMEOUT - 1)) begin
                    abort      = 1'b1;
                    state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (evt) begin
                    take_evt = 1'b1;
                    if (cmd_s == CMD_RUN) begin
                        state_next = ST_RUN;
                    end else if (is_access_cmd(cmd_s)) begin
                        state_next   = ST_ACCESS;
                        start_access = 1'b1;
                    end
                end
            end
            default: begin
                state_next = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cmd_reg   <= CMD_RUN;
            addr_reg  <= '0;
            timer     <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            data_out  <= '0;
        end else begin
            if (take_evt) begin
                cmd_reg  <= cmd_s;
                addr_reg <= addr_s;
            end
            if (start_access) begin
                mem_req   <= 1'b1;
                mem_we    <= (next_cmd == CMD_WRITE);
                mem_addr  <= addr_s;
                mem_wdata <= data_s;
                timer     <= '0;
            end else if (state == ST_ACCESS) begin
                if (ack_done) begin
                    mem_req  <= 1'b0;
                    data_out <= mem_we ? mem_wdata[15:0] : mem_rdata[15:0];
                end else if (abort) begin
                    mem_req  <= 1'b0;
                    data_out <= ERR_PATTERN;
                end else begin
                    timer <= timer + TIMER_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_debug_port.sv
// tb/tb_debug_port.sv - scoreboard bench for debug_port with an in-process memory responder
module tb_debug_port;
    import debug_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr_in;
    logic [31:0] data_in;
    logic [1:0]  cmd;
    logic [15:0] data_out;
    logic        cpu_halt;
    logic        busy;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    debug_port dut (
        .clk       (clk),
        .reset     (reset),
        .addr_in   (addr_in),
        .data_in   (data_in),
        .cmd       (cmd),
        .data_out  (data_out),
        .cpu_halt  (cpu_halt),
        .busy      (busy),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [15:0] dout;
    } acc_t;

    acc_t        exp_q[$];
    acc_t        cur;
    bit          have_cur;
    int          pass_cnt;
    int          check_cnt;
    int          req_count;
    int          req_len;
    int          last_len;
    int          ack_delay;
    bit          stray_ack;
    bit          req_prev;
    logic [31:0] rd_val;
    logic [31:0] hold_addr;
    logic [31:0] hold_wdata;

    task automatic expect_access(input logic we, input logic [31:0] a,
                                 input logic [31:0] wd, input logic [15:0] dout);
        acc_t e;
        e.we = we; e.addr = a; e.wdata = wd; e.dout = dout;
        exp_q.push_back(e);
    endtask

    // One cycle: observe DUT at the falling edge, score requests, then drive the memory side.
    task automatic tick();
        @(negedge clk);
        if (mem_req) begin
            if (!req_prev) begin
                req_len   = 0;
                req_count++;
                hold_addr  = mem_addr;
                hold_wdata = mem_wdata;
                check_cnt++;
                if (exp_q.size() == 0) begin
                    have_cur = 1'b0;
                    $display("FAIL unexpected_req: got we=%0b addr=%h wdata=%h, want no request",
                             mem_we, mem_addr, mem_wdata);
                end else begin
                    cur      = exp_q.pop_front();
                    have_cur = 1'b1;
                    if ({mem_we, mem_addr, mem_wdata} !== {cur.we, cur.addr, cur.wdata})
                        $display("FAIL req_fields: got we=%0b addr=%h wdata=%h, want we=%0b addr=%h wdata=%h",
                                 mem_we, mem_addr, mem_wdata, cur.we, cur.addr, cur.wdata);
                    else
                        pass_cnt++;
                end
            end else if (mem_addr !== hold_addr || mem_wdata !== hold_wdata) begin
                check_cnt++;
                $display("FAIL req_stable: got addr=%h wdata=%h, want addr=%h wdata=%h",
                         mem_addr, mem_wdata, hold_addr, hold_wdata);
                hold_addr  = mem_addr;
                hold_wdata = mem_wdata;
            end
            req_len++;
        end else if (req_prev) begin
            last_len = req_len;
            if (have_cur) begin
                check_cnt++;
                if (data_out !== cur.dout)
                    $display("FAIL access_result: got data_out=%h, want %h", data_out, cur.dout);
                else
                    pass_cnt++;
                have_cur = 1'b0;
            end
        end
        mem_ack = 1'b0;
        if (stray_ack) begin
            mem_ack   = 1'b1;
            mem_rdata = 32'hDEAD_BEEF;
            stray_ack = 1'b0;
        end else if (mem_req && ack_delay > 0 && req_len == ack_delay) begin
            mem_ack   = 1'b1;
            mem_rdata = rd_val;
        end
        req_prev = mem_req;
    endtask

    task automatic wait_done(input string name, input int max_cycles);
        int n = 0;
        while ((exp_q.size() != 0 || mem_req || have_cur) && n < max_cycles) begin
            tick();
            n++;
        end
        check_cnt++;
        if (n >= max_cycles)
            $display("FAIL %s_timeout: got %0d cycles still pending, want completion", name, n);
        else
            pass_cnt++;
    endtask

    task automatic wait_req(input string name, input int max_cycles);
        int n = 0;
        while (!mem_req && n < max_cycles) begin
            tick();
            n++;
        end
        check_cnt++;
        if (!mem_req)
            $display("FAIL %s_no_req: got mem_req=0 after %0d cycles, want 1", name, n);
        else
            pass_cnt++;
    endtask

    task automatic test_reset();
        reset = 1'b1; cmd = 2'b00; addr_in = '0; data_in = '0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check_cnt++;
        if ({cpu_halt, busy, mem_req, mem_we} !== 4'b0000)
            $display("FAIL reset_ctrl: got halt/busy/req/we=%b, want 0000",
                     {cpu_halt, busy, mem_req, mem_we});
        else pass_cnt++;
        check_cnt++;
        if (mem_addr !== 32'h0 || mem_wdata !== 32'h0)
            $display("FAIL reset_bus: got addr=%h wdata=%h, want 0 0", mem_addr, mem_wdata);
        else pass_cnt++;
        check_cnt++;
        if (data_out !== 16'h0)
            $display("FAIL reset_dout: got %h, want 0000", data_out);
        else pass_cnt++;
        check_cnt++;
        if (dut.state !== ST_RUN)
            $display("FAIL reset_state: got %0d, want %0d", dut.state, ST_RUN);
        else pass_cnt++;
    endtask

    task automatic test_halt_only();
        int base = req_count;
        cmd = 2'b01;
        for (int i = 1; i <= 5; i++) begin
            tick();
            check_cnt++;
            if (cpu_halt !== (i >= 3))
                $display("FAIL halt_rise_c%0d: got %b, want %b", i, cpu_halt, (i >= 3));
            else pass_cnt++;
        end
        cmd = 2'b00;
        for (int i = 1; i <= 5; i++) begin
            tick();
            check_cnt++;
            if (cpu_halt !== (i < 3))
                $display("FAIL halt_fall_c%0d: got %b, want %b", i, cpu_halt, (i < 3));
            else pass_cnt++;
        end
        check_cnt++;
        if (req_count != base)
            $display("FAIL halt_no_req: got %0d requests, want 0", req_count - base);
        else pass_cnt++;
    endtask

    task automatic test_read();
        int base = req_count;
        ack_delay = 3; rd_val = 32'h0000_1234;
        addr_in = 32'h4; data_in = 32'h0;
        expect_access(1'b0, 32'h4, 32'h0, 16'h1234);
        cmd = 2'b10;
        wait_done("read", 50);
        check_cnt++;
        if (cpu_halt !== 1'b1 || dut.state !== ST_HOLD)
            $display("FAIL read_hold: got halt=%b state=%0d, want 1 %0d", cpu_halt, dut.state, ST_HOLD);
        else pass_cnt++;
        check_cnt++;
        if (req_count - base != 1)
            $display("FAIL read_count: got %0d, want 1", req_count - base);
        else pass_cnt++;
    endtask

    task automatic test_write();
        int base = req_count;
        ack_delay = 1;
        addr_in = 32'h8; data_in = 32'h2A;
        expect_access(1'b1, 32'h8, 32'h2A, 16'h002A);
        cmd = 2'b11;
        wait_done("write", 50);
        repeat (100) tick();
        check_cnt++;
        if (req_count - base != 1)
            $display("FAIL write_once: got %0d writes, want 1", req_count - base);
        else pass_cnt++;
        check_cnt++;
        if (data_out !== 16'h002A)
            $display("FAIL write_echo_held: got %h, want 002a", data_out);
        else pass_cnt++;
    endtask

    task automatic test_timeout();
        ack_delay = 16; rd_val = 32'h5555_CAFE;
        addr_in = 32'h14;
        expect_access(1'b0, 32'h14, data_in, 16'hCAFE);
        cmd = 2'b10;
        wait_done("ack_at_limit", 60);
        check_cnt++;
        if (last_len != 16)
            $display("FAIL ack_at_limit_len: got %0d, want 16", last_len);
        else pass_cnt++;
        ack_delay = 0;
        addr_in = 32'h10;
        expect_access(1'b0, 32'h10, data_in, 16'hEEEE);
        wait_done("abort", 60);
        check_cnt++;
        if (last_len != 16)
            $display("FAIL abort_len: got %0d, want 16", last_len);
        else pass_cnt++;
        check_cnt++;
        if (busy !== 1'b0 || data_out !== 16'hEEEE)
            $display("FAIL abort_state: got busy=%b dout=%h, want 0 eeee", busy, data_out);
        else pass_cnt++;
    endtask

    task automatic test_cmd_change_mid_access();
        int base = req_count;
        ack_delay = 5; rd_val = 32'hBEEF_5678;
        addr_in = 32'h20; data_in = 32'h77;
        expect_access(1'b0, 32'h20, 32'h77, 16'h5678);
        expect_access(1'b1, 32'h20, 32'h77, 16'h0077);
        wait_req("mid_change", 20);
        cmd = 2'b11;
        wait_done("mid_change", 80);
        check_cnt++;
        if (req_count - base != 2)
            $display("FAIL mid_change_count: got %0d, want 2", req_count - base);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_access();
        ack_delay = 0;
        addr_in = 32'h30;
        expect_access(1'b0, 32'h30, data_in, 16'h0000);
        cmd = 2'b10;
        wait_req("rst_mid", 20);
        repeat (2) tick();
        reset = 1'b1; cmd = 2'b00;
        tick();
        reset = 1'b0; stray_ack = 1'b1;
        repeat (3) tick();
        check_cnt++;
        if (mem_req !== 1'b0 || data_out !== 16'h0)
            $display("FAIL rst_mid_bus: got req=%b dout=%h, want 0 0000", mem_req, data_out);
        else pass_cnt++;
        check_cnt++;
        if (cpu_halt !== 1'b0 || dut.state !== ST_RUN)
            $display("FAIL rst_mid_state: got halt=%b state=%0d, want 0 %0d", cpu_halt, dut.state, ST_RUN);
        else pass_cnt++;
        check_cnt++;
        if (exp_q.size() != 0 || have_cur)
            $display("FAIL rst_mid_scoreboard: got %0d pending, want 0", exp_q.size());
        else pass_cnt++;
    endtask

    initial begin
        pass_cnt = 0; check_cnt = 0; req_count = 0; req_len = 0; last_len = 0;
        ack_delay = 0; stray_ack = 1'b0; req_prev = 1'b0; have_cur = 1'b0;
        rd_val = '0; hold_addr = '0; hold_wdata = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        reset = 1'b1; cmd = 2'b00; addr_in = '0; data_in = '0;
        test_reset();
        test_halt_only();
        test_read();
        test_write();
        test_timeout();
        test_cmd_change_mid_access();
        test_reset_mid_access();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule

// File: doc/debug_port.md
DEBUG_PORT -- requirements
Module: debug_port

Interface
REQ-001 Parameter: TIMEOUT, 16, max cycles ACCESS waits for mem_ack before abort.
REQ-002 Parameter: ERR_PATTERN, 16'hEEEE, data_out value after an aborted access.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 reset  input  1  reset is synchronous and active-high.
REQ-005 addr_in  input  32  target word address from board switches (asynchronous source).
REQ-006 data_in  input  32  write data from board switches (asynchronous source).
REQ-007 cmd  input  2  debug command: 00 RUN, 01 HALT, 10 READ, 11 WRITE (asynchronous source).
REQ-008 data_out  output  16  result shown on 4-digit display (read data, write echo, or ERR_PATTERN).
REQ-009 cpu_halt  output  1  freezes CPU pipeline while high.
REQ-010 busy  output  1  high while a memory access is outstanding.
REQ-011 mem_req  output  1  memory access request, held until ack or timeout.
REQ-012 mem_we  output  1  1 = write, 0 = read; valid while mem_req high.
REQ-013 mem_addr  output  32  access address; valid while mem_req high.
REQ-014 mem_wdata  output  32  write data; valid while mem_req high.
REQ-015 mem_rdata  input  32  read data, valid in the cycle mem_ack is high.
REQ-016 mem_ack  input  1  single-cycle completion strobe from memory.

Function
REQ-017 addr_in, data_in, cmd SHALL pass a 2-flop synchronizer; all decisions use synchronized values (2-cycle input latency).
REQ-018 An event SHALL be any change of synchronized cmd versus the registered command value, or, while cmd stays READ, any change of synchronized addr_in.
REQ-019 States SHALL be RUN, HALT, ACCESS, HOLD; busy = (state == ACCESS).
REQ-020 RUN: cpu_halt=0; on event with cmd 01 -> HOLD, cmd 10/11 -> HALT; cpu_halt=1 from the first cycle after leaving RUN.
REQ-021 HALT: one drain cycle with cpu_halt=1, then -> ACCESS.
REQ-022 ACCESS: mem_req=1, mem_we=(cmd==11), mem_addr/mem_wdata captured on entry and held stable until exit.
REQ-023 mem_ack high in ACCESS: read -> data_out <= mem_rdata[15:0]; write -> data_out <= data_in[15:0]; mem_req low next cycle; -> HOLD.
REQ-024 No ack within TIMEOUT ACCESS cycles: mem_req drops, data_out <= ERR_PATTERN, -> HOLD.
REQ-025 mem_ack outside ACCESS SHALL be ignored; ack and timeout in the same cycle SHALL count as ack.
REQ-026 HOLD: cpu_halt=1; event with cmd 00 -> RUN (cpu_halt=0 next cycle); cmd 10/11 -> ACCESS directly; cmd 01 stays HOLD.
REQ-027 Events arising during ACCESS SHALL NOT abort the access; the registered command is not updated, so the change is detected in HOLD.
REQ-028 WRITE SHALL issue exactly one memory write per entry into cmd 11; READ re-issues only on address change.
REQ-029 data_out SHALL hold its last value in RUN, HALT, HOLD.

Reset
REQ-030 On reset: state RUN, cpu_halt=0, busy=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, data_out=0, synchronizers 0, registered command 00, timer 0.
REQ-031 Reset during ACCESS SHALL drop mem_req at that edge; a later mem_ack SHALL have no effect.

Structure
REQ-032 Shared package debug_pkg SHALL hold cmd encodings, state encoding, ERR_PATTERN and TIMEOUT default.
REQ-033 Synchronizer SHALL be a separate parameterized-width sub-module sync_2ff, instantiated once for the {cmd, addr_in, data_in} bundle.

Verification
REQ-034 cmd 00->10, addr 0x04, memory acks after 3 cycles with rdata 0x0000_1234 -> cpu_halt=1, one mem_req (we=0, addr 0x04), data_out=0x1234, state HOLD.
REQ-035 cmd 11, addr 0x08, data 0x2A, ack after 1 cycle -> exactly one write (addr 0x08, wdata 0x2A), data_out=0x002A; cmd held 100 cycles -> no second write.
REQ-036 cmd 10, memory never acks -> mem_req high exactly 16 cycles, then low, data_out=0xEEEE, busy=0.
REQ-037 cmd 10 to 11 during outstanding read, ack after 5 cycles -> read completes (data_out = rdata), then one write issued from HOLD.
REQ-038 cmd 10 with READ pending, reset pulsed mid-access, ack next cycle -> mem_req=0, data_out=0, cpu_halt=0, state RUN.
REQ-039 cmd 01 then 00 -> cpu_halt high from 3rd cycle after change, low 3 cycles after return to 00, no mem_req.
